// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-128 control FSM: state encoding,
// round-index type, permutation lengths and the registered-output bundle.
package ascon_pack;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT_AD,
    ST_AD,
    ST_WAIT_PT,
    ST_PT,
    ST_FINAL,
    ST_DONE
  } ctrl_state_t;

  typedef logic [3:0] round_t;

  localparam int unsigned ROUNDS_A = 12;
  localparam int unsigned ROUNDS_B = 6;

  // Both permutations end on index 11; a shorter p^b starts later in the table.
  localparam round_t PA_START   = round_t'(12 - ROUNDS_A);
  localparam round_t PB_START   = round_t'(12 - ROUNDS_B);
  localparam round_t LAST_ROUND = 4'd11;

  typedef struct packed {
    logic init;
    logic reg_state;
    logic xor_data;
    logic xor_key_begin;
    logic xor_key_end;
    logic xor_lsb;
    logic cipher;
    logic tag;
    logic cipher_valid;
    logic done;
    logic busy;
  } ctrl_out_t;

endpackage

// File: rtl/ascon_round_counter.sv
// 4-bit round-constant index: loadable start value, +1 per enabled cycle,
// flags the last round. Exposes its next value so outputs can be registered.
module ascon_round_counter
  import ascon_pack::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic [3:0] count_o,
  output logic [3:0] count_next_o,
  output logic       last_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign last_o       = (count_q == LAST_ROUND);

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 control FSM: sequences Init p^a, AD/PT p^b blocks and Final p^a.
// Optional decryption mode is built with `define ASCON_DECRYPT_EN.
module ascon_ctrl_fsm
  import ascon_pack::*;
#(
  parameter int unsigned AD_BLOCKS = 1,
  parameter int unsigned PT_BLOCKS = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
`ifdef ASCON_DECRYPT_EN
  input  logic       decrypt_i,
  output logic       en_replace_data_o,
`endif
  output logic [3:0] round_o,
  output logic       init_o,
  output logic       en_reg_state_o,
  output logic       en_xor_data_o,
  output logic       en_xor_key_begin_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       cipher_valid_o,
  output logic       end_o,
  output logic       busy_o,
  output logic [2:0] state_dbg_o
);

  // Handshake: there is no ready. start_i is consumed in the cycle it is seen
  // high in IDLE/DONE, data_valid_i in the cycle it is seen high in WAIT_AD or
  // WAIT_PT; in every other state both are ignored, never queued.

  localparam logic [3:0] AD_LAST = 4'(AD_BLOCKS - 1);
  localparam logic [3:0] PT_LAST = 4'(PT_BLOCKS - 1);

  ctrl_state_t state_q, state_d;
  logic [3:0]  blk_q, blk_d;
  ctrl_out_t   out_q, out_d;
  logic        data_first;

  logic        cnt_load;
  logic [3:0]  cnt_load_val;
  logic        cnt_en;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_next;
  logic        cnt_last;

`ifdef ASCON_DECRYPT_EN
  logic dec_q, dec_d;
  logic repl_q, repl_d;
`endif

  ascon_round_counter u_round_counter (
    .clk_i        (clock_i),
    .rst_i        (reset_i),
    .load_i       (cnt_load),
    .load_val_i   (cnt_load_val),
    .en_i         (cnt_en),
    .count_o      (cnt_q),
    .count_next_o (cnt_next),
    .last_o       (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    cnt_load     = 1'b0;
    cnt_load_val = PA_START;
    cnt_en       = 1'b0;
`ifdef ASCON_DECRYPT_EN
    dec_d        = dec_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d      = ST_INIT;
          blk_d        = '0;
          cnt_load     = 1'b1;
          cnt_load_val = PA_START;
`ifdef ASCON_DECRYPT_EN
          dec_d        = decrypt_i;
`endif
        end
      end
      ST_INIT: begin
        if (cnt_last) state_d = ST_WAIT_AD;
        else          cnt_en  = 1'b1;
      end
      ST_WAIT_AD: begin
        if (data_valid_i) begin
          state_d      = ST_AD;
          cnt_load     = 1'b1;
          cnt_load_val = PB_START;
        end
      end
      ST_AD: begin
        if (cnt_last) begin
          if (blk_q == AD_LAST) begin
            blk_d   = '0;
            state_d = ST_WAIT_PT;
          end else begin
            blk_d   = blk_q + 4'd1;
            state_d = ST_WAIT_AD;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WAIT_PT: begin
        if (data_valid_i) begin
          cnt_load = 1'b1;
          // The last (padded) plaintext block is absorbed by Final itself.
          if (blk_q == PT_LAST) begin
            state_d      = ST_FINAL;
            cnt_load_val = PA_START;
          end else begin
            state_d      = ST_PT;
            cnt_load_val = PB_START;
          end
        end
      end
      ST_PT: begin
        if (cnt_last) begin
          blk_d   = blk_q + 4'd1;
          state_d = ST_WAIT_PT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_FINAL: begin
        if (cnt_last) state_d = ST_DONE;
        else          cnt_en  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state/round so they land in the same
  // cycle as the state they describe, straight out of flops.
  always_comb begin
    out_d      = '0;
    data_first = 1'b0;
`ifdef ASCON_DECRYPT_EN
    repl_d     = 1'b0;
`endif
    case (state_d)
      ST_INIT: begin
        out_d.reg_state   = 1'b1;
        out_d.init        = (cnt_next == PA_START);
        out_d.xor_key_end = (cnt_next == LAST_ROUND);
      end
      ST_AD: begin
        out_d.reg_state = 1'b1;
        out_d.xor_data  = (cnt_next == PB_START);
        out_d.xor_lsb   = (cnt_next == LAST_ROUND) && (blk_d == AD_LAST);
      end
      ST_PT: begin
        out_d.reg_state = 1'b1;
        data_first      = (cnt_next == PB_START);
        out_d.cipher    = data_first;
      end
      ST_FINAL: begin
        out_d.reg_state     = 1'b1;
        data_first          = (cnt_next == PA_START);
        out_d.cipher        = data_first;
        out_d.xor_key_begin = data_first;
        out_d.xor_key_end   = (cnt_next == LAST_ROUND);
        out_d.tag           = (cnt_next == LAST_ROUND);
      end
      default: ;
    endcase
`ifdef ASCON_DECRYPT_EN
    out_d.xor_data = out_d.xor_data | (data_first & ~dec_d);
    repl_d         = data_first & dec_d;
`else
    out_d.xor_data = out_d.xor_data | data_first;
`endif
    out_d.busy         = (state_d != ST_IDLE) && (state_d != ST_DONE);
    out_d.done         = (state_d == ST_DONE);
    out_d.cipher_valid = out_q.cipher;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      out_q   <= '0;
`ifdef ASCON_DECRYPT_EN
      dec_q   <= 1'b0;
      repl_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      out_q   <= out_d;
`ifdef ASCON_DECRYPT_EN
      dec_q   <= dec_d;
      repl_q  <= repl_d;
`endif
    end
  end

`ifdef ASCON_DECRYPT_EN
  assign en_replace_data_o = repl_q;
`endif
  assign round_o            = cnt_q;
  assign init_o             = out_q.init;
  assign en_reg_state_o     = out_q.reg_state;
  assign en_xor_data_o      = out_q.xor_data;
  assign en_xor_key_begin_o = out_q.xor_key_begin;
  assign en_xor_key_end_o   = out_q.xor_key_end;
  assign en_xor_lsb_o       = out_q.xor_lsb;
  assign en_cipher_o        = out_q.cipher;
  assign en_tag_o           = out_q.tag;
  assign cipher_valid_o     = out_q.cipher_valid;
  assign end_o              = out_q.done;
  assign busy_o             = out_q.busy;
  assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: builds the expected per-cycle enable trace of a
// whole run from phase rules (p^a / waits / p^b) and replays random stimulus.
module tb_ascon_ctrl_fsm;
  import ascon_pack::*;

  localparam int AD_B = 1;
  localparam int PT_B = 3;
  localparam int W    = 17;  // {round_care, enables[11:0], round[3:0]}

  localparam int K_INIT = 0;
  localparam int K_AD   = 1;
  localparam int K_PT   = 2;
  localparam int K_FIN  = 3;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       data_valid_i;
  logic [3:0] round_o;
  logic       init_o, en_reg_state_o, en_xor_data_o, en_xor_key_begin_o;
  logic       en_xor_key_end_o, en_xor_lsb_o, en_cipher_o, en_tag_o;
  logic       cipher_valid_o, end_o, busy_o;
  logic [2:0] state_dbg_o;
  logic       repl_obs;
`ifdef ASCON_DECRYPT_EN
  logic       decrypt_i;
  logic       en_replace_data_o;
  assign repl_obs = en_replace_data_o;
`else
  assign repl_obs = 1'b0;
`endif

  always #5 clock_i = ~clock_i;

  ascon_ctrl_fsm #(.AD_BLOCKS(AD_B), .PT_BLOCKS(PT_B)) dut (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .start_i            (start_i),
    .data_valid_i       (data_valid_i),
`ifdef ASCON_DECRYPT_EN
    .decrypt_i          (decrypt_i),
    .en_replace_data_o  (en_replace_data_o),
`endif
    .round_o            (round_o),
    .init_o             (init_o),
    .en_reg_state_o     (en_reg_state_o),
    .en_xor_data_o      (en_xor_data_o),
    .en_xor_key_begin_o (en_xor_key_begin_o),
    .en_xor_key_end_o   (en_xor_key_end_o),
    .en_xor_lsb_o       (en_xor_lsb_o),
    .en_cipher_o        (en_cipher_o),
    .en_tag_o           (en_tag_o),
    .cipher_valid_o     (cipher_valid_o),
    .end_o              (end_o),
    .busy_o             (busy_o),
    .state_dbg_o        (state_dbg_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic [2:0]   stim_q[$];  // {start, data_valid, decrypt}
  logic         prev_cipher = 1'b0;
  int           final_idx   = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Enable bit order: init, reg, xdata, kbeg, kend, lsb, cipher, tag, cv, end, busy, repl
  function automatic logic [11:0] observed();
    return {init_o, en_reg_state_o, en_xor_data_o, en_xor_key_begin_o,
            en_xor_key_end_o, en_xor_lsb_o, en_cipher_o, en_tag_o,
            cipher_valid_o, end_o, busy_o, repl_obs};
  endfunction

  task automatic push(input logic [11:0] en, input logic [3:0] rnd, input logic care,
                      input logic st, input logic dv, input logic dec);
    en[3] = prev_cipher;  // cipher_valid trails en_cipher by one cycle
    prev_cipher = en[5];
    exp_q.push_back({care, en, rnd});
    stim_q.push_back({st, dv, dec});
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic phase(input int kind, input logic last_ad, input logic dec);
    int s;
    s = (kind == K_AD || kind == K_PT) ? 12 - ROUNDS_B : 12 - ROUNDS_A;
    for (int r = s; r < 12; r++) begin
      logic [11:0] en;
      logic first, fin;
      en = '0;
      first = (r == s);
      fin = (r == 11);
      en[10] = 1'b1;
      en[1]  = 1'b1;
      case (kind)
        K_INIT: begin en[11] = first; en[7] = fin; end
        K_AD:   begin en[9] = first; en[6] = fin & last_ad; end
        K_PT:   begin en[5] = first; en[9] = first & ~dec; en[0] = first & dec; end
        default: begin
          en[5] = first; en[8] = first; en[9] = first & ~dec; en[0] = first & dec;
          en[7] = fin; en[4] = fin;
          if (r == 4) final_idx = exp_q.size();
        end
      endcase
      push(en, 4'(r), 1'b1, rbit(), rbit(), rbit());
    end
  endtask

  task automatic wait_phase(input int w);
    for (int i = 0; i < w; i++) push(12'h002, 4'd0, 1'b0, rbit(), 1'b0, rbit());
    push(12'h002, 4'd0, 1'b0, rbit(), 1'b1, rbit());
  endtask

  task automatic build_run(input int w_ad0, input int w_pt0, input int wmax,
                           input logic dec, input logic from_done, input int tail);
    push(from_done ? 12'h004 : 12'h000, 4'd0, 1'b0, 1'b1, rbit(), dec);
    phase(K_INIT, 1'b0, dec);
    for (int b = 0; b < AD_B; b++) begin
      wait_phase(b == 0 ? w_ad0 : int'($urandom_range(0, wmax)));
      phase(K_AD, b == AD_B - 1, dec);
    end
    for (int b = 0; b < PT_B; b++) begin
      wait_phase(b == 0 ? w_pt0 : int'($urandom_range(0, wmax)));
      phase(b == PT_B - 1 ? K_FIN : K_PT, 1'b0, dec);
    end
    for (int t = 0; t < tail; t++) push(12'h004, 4'd0, 1'b0, 1'b0, rbit(), rbit());
  endtask

  task automatic play(input int abort_at, output int first_end);
    int k;
    k = 0;
    first_end = -1;
    while (exp_q.size() > 0) begin
      logic [2:0]   s;
      logic [W-1:0] e;
      @(posedge clock_i);
      #1;
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      start_i      = s[2];
      data_valid_i = s[1];
`ifdef ASCON_DECRYPT_EN
      decrypt_i    = s[0];
`endif
      check_eq($sformatf("enables@%0d", k), 32'(observed()), 32'(e[15:4]));
      if (e[16]) check_eq($sformatf("round@%0d", k), 32'(round_o), 32'(e[3:0]));
      if (end_o && first_end < 0) first_end = k;
      if (k == abort_at) begin
        reset_i = 1'b1;
        exp_q.delete();
        stim_q.delete();
      end
      k++;
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_en"}, 32'(observed()), 32'd0);
    check_eq({tag, "_round"}, 32'(round_o), 32'd0);
    check_eq({tag, "_state"}, 32'(state_dbg_o), 32'(ST_IDLE));
  endtask

  function automatic logic pick_dec(input logic want);
`ifdef ASCON_DECRYPT_EN
    return want;
`else
    return 1'b0 & want;
`endif
  endfunction

  initial begin
    int fe;
    reset_i      = 1'b1;
    start_i      = 1'b0;
    data_valid_i = 1'b0;
`ifdef ASCON_DECRYPT_EN
    decrypt_i    = 1'b0;
`endif
    repeat (3) @(posedge clock_i);
    #1;
    check_reset("reset");
    reset_i = 1'b0;

    // Back-to-back data: start cycle + Init + (wait+p^b) per AD block +
    // one wait per PT block + p^b per non-final PT block + Final.
    build_run(0, 0, 0, 1'b0, 1'b0, 3);
    play(-1, fe);
    check_eq("latency", 32'(fe), 32'(1 + ROUNDS_A + AD_B * (1 + ROUNDS_B) + PT_B
                                      + ROUNDS_B * (PT_B - 1) + ROUNDS_A));

    // Long stalls in WAIT_AD and WAIT_PT, restarted from DONE.
    build_run(20, 20, 3, pick_dec(1'b1), 1'b1, 2);
    play(-1, fe);

    // Reset in the fifth Final cycle, then a clean run from IDLE.
    build_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 3,
              pick_dec(rbit()), 1'b1, 0);
    play(final_idx, fe);
    @(posedge clock_i);
    #1;
    check_reset("final_abort");
    reset_i      = 1'b0;
    start_i      = 1'b0;
    prev_cipher  = 1'b0;

    for (int i = 0; i < 4; i++) begin
      build_run(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 4,
                pick_dec(rbit()), i > 0, 2 + int'($urandom_range(0, 2)));
      play(-1, fe);
      check_eq($sformatf("run%0d_end", i), 32'(end_o), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
